// File: rtl/stack_pkg.sv
// Shared definitions for the push/pop stack command interface and its controller.
package stack_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RSP  = 2'd2
  } state_t;

endpackage

// File: rtl/stack_ctrl_if.sv
// Request/response handshake between the sequencer (master) and stack_ctrl (slave).
interface stack_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/stack_depth_cnt.sv
// Occupancy counter for the stack, with full/empty and sticky overflow/underflow flags.
module stack_depth_cnt #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  input  logic          push_try,
  input  logic          pop_try,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err_ovf,
  output logic          err_unf
);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Guards keep the count inside 0..DEPTH even if a caller misbehaves.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + CW'(1);
    end else if (dec && !inc && !empty) begin
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (push_try && full)  err_ovf <= 1'b1;
      if (pop_try  && empty) err_unf <= 1'b1;
    end
  end

endmodule

// File: rtl/stack_ctrl.sv
// Initiator for a reset-less shift-register stack: issues push/pop on stk_s/stk_i, captures T.
// Optional peek (op 11) is enabled by defining STACK_CTRL_PEEK_EN.
//
// state | meaning
// IDLE  | ready for a request
// CMD   | stk_s carries the accepted op for one cycle (00 for peek)
// RSP   | response held on rsp_valid until rsp_ready
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       ck,
  input  logic                       rst_n,
  stack_ctrl_if.slave                bus,
  output logic [1:0]                 stk_s,
  output logic [WIDTH-1:0]           stk_i,
  input  logic [WIDTH-1:0]           stk_t,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       err_ovf,
  output logic                       err_unf
);

  state_t           state, state_nxt;
  logic [1:0]       stk_s_nxt;
  logic [WIDTH-1:0] stk_i_nxt;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_nxt;
  logic [1:0]       cmd_op, cmd_op_nxt;
  logic             inc, dec, push_try, pop_try;
  logic             accept;

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RSP);
  assign bus.rsp_data  = rsp_data_q;
  assign accept        = bus.req_valid && (state == IDLE);

  stack_depth_cnt #(.DEPTH(DEPTH)) u_depth_cnt (
    .ck       (ck),
    .rst_n    (rst_n),
    .inc      (inc),
    .dec      (dec),
    .push_try (push_try),
    .pop_try  (pop_try),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf)
  );

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      stk_s      <= OP_NOP;
      stk_i      <= '0;
      rsp_data_q <= '0;
      cmd_op     <= OP_NOP;
    end else begin
      state      <= state_nxt;
      stk_s      <= stk_s_nxt;
      stk_i      <= stk_i_nxt;
      rsp_data_q <= rsp_data_nxt;
      cmd_op     <= cmd_op_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    stk_s_nxt    = OP_NOP;
    stk_i_nxt    = stk_i;
    rsp_data_nxt = rsp_data_q;
    cmd_op_nxt   = cmd_op;
    inc          = 1'b0;
    dec          = 1'b0;
    push_try     = 1'b0;
    pop_try      = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.req_op)
            OP_PUSH: begin
              push_try = 1'b1;
              if (!full) begin
                stk_s_nxt  = OP_PUSH;
                stk_i_nxt  = bus.req_data;
                cmd_op_nxt = OP_PUSH;
                state_nxt  = CMD;
              end
            end
            OP_POP: begin
              pop_try = 1'b1;
              if (!empty) begin
                stk_s_nxt  = OP_POP;
                cmd_op_nxt = OP_POP;
                state_nxt  = CMD;
              end
            end
`ifdef STACK_CTRL_PEEK_EN
            OP_PEEK: begin
              // Peek reads T without shifting, so the stack sees no command.
              pop_try = 1'b1;
              if (!empty) begin
                cmd_op_nxt = OP_PEEK;
                state_nxt  = CMD;
              end
            end
`endif
            default: ;
          endcase
        end
      end
      CMD: begin
        state_nxt = IDLE;
        case (cmd_op)
          OP_PUSH: inc = 1'b1;
          OP_POP: begin
            // stk_t still shows the pre-shift top at this edge.
            dec          = 1'b1;
            rsp_data_nxt = stk_t;
            state_nxt    = RSP;
          end
          OP_PEEK: begin
            rsp_data_nxt = stk_t;
            state_nxt    = RSP;
          end
          default: ;
        endcase
      end
      RSP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural shift-register stack attached.
module tb_stack_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             ck;
  logic             rst_n;
  logic [1:0]       stk_s;
  logic [WIDTH-1:0] stk_i;
  logic [WIDTH-1:0] stk_t;
  logic [2:0]       count;
  logic             full, empty, err_ovf, err_unf;

  int errors = 0;
  int checks = 0;

  stack_ctrl_if #(.WIDTH(WIDTH)) bus ();

  stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .ck      (ck),
    .rst_n   (rst_n),
    .bus     (bus),
    .stk_s   (stk_s),
    .stk_i   (stk_i),
    .stk_t   (stk_t),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .err_ovf (err_ovf),
    .err_unf (err_unf)
  );

  // Stack model: no reset, push shifts down, pop shifts up, T is entry 0.
  logic [WIDTH-1:0] stk_mem [DEPTH];
  assign stk_t = stk_mem[0];

  always @(posedge ck) begin
    if (stk_s == 2'b10) begin
      stk_mem[0] <= stk_i;
      for (int k = 1; k < DEPTH; k++) stk_mem[k] <= stk_mem[k-1];
    end else if (stk_s == 2'b01) begin
      for (int k = 0; k < DEPTH - 1; k++) stk_mem[k] <= stk_mem[k+1];
      stk_mem[DEPTH-1] <= '0;
    end
  end

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] exp_cnt);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b10;
    bus.req_data  = d;
    tick();
    bus.req_valid = 1'b0;
    chk("push_stk_s", 32'(stk_s), 32'h2);
    chk("push_stk_i", 32'(stk_i), 32'(d));
    chk("push_busy", 32'(bus.req_ready), 32'h0);
    tick();
    chk("push_stk_s_idle", 32'(stk_s), 32'h0);
    chk("push_count", 32'(count), 32'(exp_cnt));
  endtask

  task automatic pop(input logic [7:0] exp_d, input logic [2:0] exp_cnt);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    tick();
    bus.req_valid = 1'b0;
    chk("pop_stk_s", 32'(stk_s), 32'h1);
    tick();
    chk("pop_stk_s_idle", 32'(stk_s), 32'h0);
    chk("pop_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("pop_rsp_data", 32'(bus.rsp_data), 32'(exp_d));
    chk("pop_count", 32'(count), 32'(exp_cnt));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("pop_rsp_done", 32'(bus.rsp_valid), 32'h0);
    chk("pop_ready_back", 32'(bus.req_ready), 32'h1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    #12;
    chk("rst_stk_s", 32'(stk_s), 32'h0);
    chk("rst_stk_i", 32'(stk_i), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
    chk("rst_err_ovf", 32'(err_ovf), 32'h0);
    chk("rst_err_unf", 32'(err_unf), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'h1);
    rst_n = 1'b1;
    tick();

    // Reset asserted while a push is on stk_s
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b10;
    bus.req_data  = 8'hAA;
    tick();
    bus.req_valid = 1'b0;
    chk("midcmd_stk_s", 32'(stk_s), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("midrst_stk_s", 32'(stk_s), 32'h0);
    chk("midrst_count", 32'(count), 32'h0);
    chk("midrst_err_ovf", 32'(err_ovf), 32'h0);
    chk("midrst_err_unf", 32'(err_unf), 32'h0);
    chk("midrst_ready", 32'(bus.req_ready), 32'h1);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_count", 32'(count), 32'h0);

    // Fill the stack
    push(8'hA5, 3'd1);
    chk("not_full_1", 32'(full), 32'h0);
    chk("not_empty_1", 32'(empty), 32'h0);
    push(8'h3C, 3'd2);
    push(8'hF0, 3'd3);
    chk("not_full_3", 32'(full), 32'h0);
    push(8'h0F, 3'd4);
    chk("full_4", 32'(full), 32'h1);

    // Overflow attempt
    chk("ovf_ready_before", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b10;
    bus.req_data  = 8'h77;
    tick();
    bus.req_valid = 1'b0;
    chk("ovf_stk_s", 32'(stk_s), 32'h0);
    chk("ovf_err", 32'(err_ovf), 32'h1);
    chk("ovf_err_unf", 32'(err_unf), 32'h0);
    chk("ovf_count", 32'(count), 32'h4);
    chk("ovf_ready_after", 32'(bus.req_ready), 32'h1);
    tick();
    chk("ovf_stk_s_2", 32'(stk_s), 32'h0);
    chk("ovf_count_2", 32'(count), 32'h4);

    // Drain in LIFO order
    pop(8'h0F, 3'd3);
    chk("not_full_after_pop", 32'(full), 32'h0);
    pop(8'hF0, 3'd2);
    pop(8'h3C, 3'd1);
    pop(8'hA5, 3'd0);
    chk("empty_after_drain", 32'(empty), 32'h1);

    // Underflow attempt
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    tick();
    bus.req_valid = 1'b0;
    chk("unf_stk_s", 32'(stk_s), 32'h0);
    chk("unf_err", 32'(err_unf), 32'h1);
    chk("unf_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("unf_ready", 32'(bus.req_ready), 32'h1);
    tick();
    chk("unf_rsp_valid_2", 32'(bus.rsp_valid), 32'h0);
    chk("unf_count", 32'(count), 32'h0);
    chk("ovf_sticky", 32'(err_ovf), 32'h1);

    // Response back-pressure
    push(8'h5A, 3'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    tick();
    bus.req_valid = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("hold_rsp_data", 32'(bus.rsp_data), 32'h5A);
      chk("hold_ready", 32'(bus.req_ready), 32'h0);
      tick();
    end
    chk("hold_rsp_valid_3", 32'(bus.rsp_valid), 32'h1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("hold_released", 32'(bus.rsp_valid), 32'h0);
    chk("hold_ready_back", 32'(bus.req_ready), 32'h1);
    chk("hold_count", 32'(count), 32'h0);

    // Op 11
    push(8'h81, 3'd1);
`ifdef STACK_CTRL_PEEK_EN
    for (int p = 0; p < 2; p++) begin
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b11;
      tick();
      bus.req_valid = 1'b0;
      chk("peek_stk_s", 32'(stk_s), 32'h0);
      chk("peek_busy", 32'(bus.req_ready), 32'h0);
      tick();
      chk("peek_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("peek_rsp_data", 32'(bus.rsp_data), 32'h81);
      chk("peek_count", 32'(count), 32'h1);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("peek_done", 32'(bus.rsp_valid), 32'h0);
    end
`else
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b11;
    tick();
    bus.req_valid = 1'b0;
    chk("op11_stk_s", 32'(stk_s), 32'h0);
    chk("op11_ready", 32'(bus.req_ready), 32'h1);
    tick();
    chk("op11_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("op11_rsp_data", 32'(bus.rsp_data), 32'h5A);
    chk("op11_count", 32'(count), 32'h1);
`endif
    pop(8'h81, 3'd0);
    chk("final_err_unf", 32'(err_unf), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
